// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N:1 channel multiplexer.
package mux_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL   = 2'd1,
        PRESENT = 2'd2
    } scan_state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Index width that never collapses to zero bits
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational finder for the next enabled channel in a mask.
// first=1 returns the lowest set bit; otherwise the first set bit strictly
// after cur, wrapping, so a lone set bit at cur returns cur itself.
module mux_next_ch
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 32,
    parameter int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             none
);

    // Rotating priority search over all N_CH candidate positions
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        nxt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (first) begin
                idx = SEL_W'(k);
            end else begin
                idx = SEL_W'((32'(cur) + k + 1) % N_CH);
            end
            if (!found && mask[idx]) begin
                found = 1'b1;
                nxt   = idx;
            end
        end
        none = ~found;
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// N:1 channel multiplexer with registered outputs. Manual mode follows a
// registered select; scan mode round-robins over enabled channels, dwelling
// on each before presenting one sample on a valid/ready handshake.
module mux_scan_nx1
    import mux_pkg::*;
#(
    parameter int unsigned  N_CH    = 32,
    parameter int unsigned  DATA_W  = 1,
    parameter int unsigned  DWELL_W = 8,
    localparam int unsigned SEL_W   = sel_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    scan_state_e        state;
    logic [SEL_W-1:0]   ptr;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_load;
    logic [SEL_W-1:0]   nc_idx;
    logic               nc_none;
    logic               sel_ok;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-1:0]  ptr_data;

    // dwell of 0 behaves as 1, so the counter reload saturates at 0
    assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;

    assign sel_ok   = 32'(sel) < N_CH;
    assign sel_data = sel_ok ? in_data[32'(sel)*DATA_W +: DATA_W] : '0;
    // ptr is only ever loaded from the finder, so it is always in range
    assign ptr_data = in_data[32'(ptr)*DATA_W +: DATA_W];

    // One finder serves both the IDLE exit (lowest bit) and the accept (next bit)
    mux_next_ch #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_next_ch (
        .mask  (ch_mask),
        .cur   (ptr),
        .first (state == IDLE),
        .nxt   (nc_idx),
        .none  (nc_none)
    );

    // Scan FSM, dwell counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else if (mode == MODE_MANUAL) begin
            // Any pending scan sample is dropped here
            state     <= IDLE;
            out_data  <= sel_data;
            out_ch    <= sel;
            out_valid <= sel_ok;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (!nc_none) begin
                        ptr   <= nc_idx;
                        cnt   <= dwell_load;
                        state <= DWELL;
                    end
                end
                DWELL: begin
                    if (cnt == '0) begin
                        out_data  <= ptr_data;
                        out_ch    <= ptr;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (nc_none) begin
                            state <= IDLE;
                        end else begin
                            ptr   <= nc_idx;
                            cnt   <= dwell_load;
                            state <= DWELL;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1: manual sweeps on 32- and 24-channel
// instances, then scan sequencing, backpressure, dwell, mask, reset and
// mode-switch scenarios with a queue of expected samples.
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        mode;
    logic [4:0]  sel;
    logic [31:0] ch_mask;
    logic [7:0]  dwell;
    logic        out_ready;
    logic [0:0]  out_data;
    logic [4:0]  out_ch;
    logic        out_valid;

    logic [23:0] in_data24;
    logic [4:0]  sel24;
    logic [23:0] ch_mask24;
    logic [0:0]  out_data24;
    logic [4:0]  out_ch24;
    logic        out_valid24;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [4:0] ch;
        logic       data;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_nx1 #(
        .N_CH    (32),
        .DATA_W  (1),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .mode      (mode),
        .sel       (sel),
        .ch_mask   (ch_mask),
        .dwell     (dwell),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_scan_nx1 #(
        .N_CH    (24),
        .DATA_W  (1),
        .DWELL_W (8)
    ) dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data24),
        .mode      (mode),
        .sel       (sel24),
        .ch_mask   (ch_mask24),
        .dwell     (dwell),
        .out_data  (out_data24),
        .out_ch    (out_ch24),
        .out_valid (out_valid24),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void push_exp(input int ch);
        exp_t       e;
        logic [4:0] c5;
        c5     = 5'(ch);
        e.ch   = c5;
        e.data = in_data[c5];
        exp_q.push_back(e);
    endfunction

    task automatic compare_sample(input string tag, output exp_t e);
        e = '0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_ch"}, 32'(out_ch), 32'(e.ch));
        check({tag, "_data"}, 32'(out_data), 32'(e.data));
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Consume n samples with out_ready high, checking spacing from the 2nd on
    task automatic run_scan(input int n, input int gap);
        bit   ok;
        int   prev;
        exp_t e;
        prev      = 0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_valid(ok);
            if (!ok) return;
            compare_sample("scan", e);
            if (i > 0) check("scan_gap", 32'(cyc - prev), 32'(gap));
            prev = cyc;
            @(negedge clk);
            check("accept_drop", 32'(out_valid), 32'd0);
        end
    endtask

    // Wait for the next sample and leave it pending with out_ready low
    task automatic hold(input string tag, output exp_t e);
        bit ok;
        e         = '0;
        out_ready = 1'b0;
        wait_valid(ok);
        if (ok) compare_sample(tag, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        sel24     = '0;
        in_data   = 32'hA5A5_0F0F;
        in_data24 = 24'hC3_5A96;
        ch_mask   = '0;
        ch_mask24 = '0;
        dwell     = 8'd3;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_valid24", 32'(out_valid24), 32'd0);
        rst_n = 1'b1;

        // Manual sweep; sel values 24..31 are out of range for the 24-channel copy
        for (int s = 0; s < 32; s++) begin
            sel   = 5'(s);
            sel24 = 5'(s);
            push_exp(s);
            @(negedge clk);
            compare_sample("man", e);
            check("man24_ch", 32'(out_ch24), 32'(s));
            check("man24_valid", 32'(out_valid24), (s < 24) ? 32'd1 : 32'd0);
            check("man24_data", 32'(out_data24), (s < 24) ? 32'(in_data24[5'(s)]) : 32'd0);
        end

        // Scan over channels 1,4,8 with dwell 3
        mode      = 1'b1;
        ch_mask   = 32'h0000_0112;
        dwell     = 8'd3;
        out_ready = 1'b1;
        @(negedge clk);
        check("scan_first_cycle", 32'(out_valid), 32'd0);
        push_exp(1); push_exp(4); push_exp(8);
        push_exp(1); push_exp(4); push_exp(8);
        run_scan(6, 4);

        // Backpressure: hold ch1 for 10 cycles, release for exactly one cycle
        push_exp(1);
        hold("bp", e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_stable_ch", 32'(out_ch), 32'(e.ch));
            check("bp_stable_data", 32'(out_data), 32'(e.data));
            check("bp_stable_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", 32'(out_valid), 32'd0);
        push_exp(4);
        hold("bp_next", e);

        // dwell 0 behaves like dwell 1
        dwell = 8'd0;
        push_exp(8); push_exp(1); push_exp(4); push_exp(8);
        run_scan(4, 2);
        dwell = 8'd1;
        push_exp(1); push_exp(4); push_exp(8);
        run_scan(3, 2);

        // Single channel 31 repeats
        push_exp(1);
        hold("pre31", e);
        ch_mask = 32'h8000_0000;
        dwell   = 8'd3;
        push_exp(31); push_exp(31); push_exp(31);
        run_scan(3, 4);

        // Empty mask at accept parks the sequencer
        push_exp(31);
        hold("pre_empty", e);
        ch_mask   = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("empty_mask_valid", 32'(out_valid), 32'd0);
        end

        // Reset while presenting ch4 restarts from the lowest channel
        ch_mask = 32'h0000_0112;
        push_exp(1);
        run_scan(1, 0);
        push_exp(4);
        hold("pre_rst", e);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_data", 32'(out_data), 32'd0);
        check("midrst_ch", 32'(out_ch), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        push_exp(1); push_exp(4); push_exp(8); push_exp(1);
        run_scan(4, 4);

        // Scan->manual while ch4 is pending; the sample must be lost
        push_exp(4);
        hold("pre_mode", e);
        mode      = 1'b0;
        sel       = 5'd3;
        out_ready = 1'b1;
        push_exp(3);
        @(negedge clk);
        compare_sample("mode_sw_manual", e);
        mode = 1'b1;
        @(negedge clk);
        check("mode_sw_first_scan", 32'(out_valid), 32'd0);
        push_exp(1); push_exp(4);
        run_scan(2, 4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised N:1 channel multiplexer with registered output and two modes. Manual mode is a registered select. Scan mode is an autonomous round-robin sequencer that dwells on each enabled channel, then presents one sample per channel on a valid/ready handshake. It sits between groups of per-channel status/data lines and a single downstream consumer (sampler, serialiser, debug capture).

## Interface
Parameters:
- N_CH, 32: number of input channels, ≥2.
- DATA_W, 1: bits per channel.
- DWELL_W, 8: width of the dwell-count input.
- SEL_W (localparam), $clog2(N_CH): select/channel-index width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- mode  in  1  0 = manual, 1 = scan.
- sel  in  SEL_W  manual-mode channel select.
- ch_mask  in  N_CH  scan-mode enable per channel; 1 = include.
- dwell  in  DWELL_W  scan-mode cycles spent on a channel before it is sampled; 0 is treated as 1.
- out_data  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  index of the channel in out_data.
- out_valid  out  1  out_data/out_ch are valid.
- out_ready  in  1  consumer accepts; used in scan mode only.

## Operation
- All outputs are registered. No combinational path runs from any input to any output.
- **Manual mode (mode=0):**
  - Every cycle: out_data ← channel sel, out_ch ← sel, out_valid ← 1.
  - If sel ≥ N_CH: out_data ← 0, out_ch ← sel, out_valid ← 0.
  - out_ready is ignored. The scan FSM is held in IDLE.
- **Scan mode (mode=1).** FSM states are IDLE, DWELL and PRESENT. Pointer is ptr; down-counter is cnt.
  - IDLE: out_valid=0.
    - If ch_mask≠0: ptr ← lowest set bit of ch_mask, cnt ← max(dwell,1)−1, go to DWELL.
    - Otherwise stay in IDLE.
  - DWELL: cnt decrements each cycle.
    - At cnt=0: out_data ← channel ptr (sampled this cycle), out_ch ← ptr, out_valid ← 1, go to PRESENT.
  - PRESENT: out_data, out_ch and out_valid are held stable while out_valid=1 and out_ready=0.
    - On out_valid & out_ready: out_valid ← 0, ptr ← next set bit of ch_mask strictly after ptr (wrapping N_CH−1→0), cnt ← max(dwell,1)−1, go to DWELL.
    - If ptr is the only set bit, the scan stays on ptr.
  - ch_mask and dwell are sampled only at IDLE exit and on the PRESENT accept. A channel masked mid-dwell is still sampled once.
  - If ch_mask=0 at the PRESENT accept: go to IDLE, out_valid=0.
- **Mode change:** takes effect on the next clock edge.
  - Scan→manual: the FSM goes to IDLE and any pending PRESENT sample is discarded. The next cycle shows manual output.
  - Manual→scan: the FSM starts from IDLE, and out_valid is 0 on the first scan cycle.
- **Reset** (rst_n=0 at an edge, any state, any mode):
  - out_data=0, out_ch=0, out_valid=0, state=IDLE, ptr=0, cnt=0.
  - Reset mid-PRESENT drops the sample.

## Timing
- Manual latency: 1 cycle from sel/in_data to out_data.
- Scan: IDLE→DWELL takes 1 cycle, DWELL lasts max(dwell,1) cycles, and out_valid rises on the edge ending the last DWELL cycle.
- Channel period with out_ready held 1: max(dwell,1)+1 cycles per enabled channel.
- PRESENT accept and advance to DWELL happen on the same edge, so out_valid is low for at least max(dwell,1) cycles between samples.
- out_valid never drops without acceptance except on mode change or reset.

## Structure
- Shared package mux_pkg holds:
  - scan state enum (IDLE/DWELL/PRESENT);
  - MODE_MANUAL/MODE_SCAN constants;
  - a clog2-safe SEL_W helper.
- Sub-module mux_next_ch: combinational next-enabled-channel finder.
  - Inputs: mask, current index, and a first flag for lowest-set-bit search.
  - Outputs: next index and a none flag.
  - It is used at both IDLE exit and PRESENT accept.
- The top level holds the FSM, counter, output registers and data select.

## Test plan
- Manual, N_CH=32, DATA_W=1: in_data=32'hA5A5_0F0F, sweep sel 0..31 → out_data equals in_data[sel] one cycle later, out_valid=1, out_ch=sel.
- Manual, N_CH=24: sel=25 → out_valid=0, out_data=0.
- Scan with ch_mask=32'h0000_0112, dwell=3, out_ready=1 → out_ch sequence 1,4,8,1,…, each sample 4 cycles apart, out_data matching the channel at the sample edge.
- Backpressure: scan, out_ready=0 for 10 cycles in PRESENT → out_data/out_ch/out_valid stable. Then out_ready=1 for 1 cycle → advance to the next channel.
- dwell=0 equals dwell=1 (period 2). ch_mask=0 → out_valid stays 0. Setting ch_mask=32'h8000_0000 → out_ch=31 repeatedly.
- Reset and mode-switch checks:
  - rst_n low for 1 cycle during PRESENT → all outputs 0 next cycle, restart from the lowest enabled channel.
  - mode 1→0 during PRESENT → next cycle shows manual output and the pending sample is never accepted.
